block_mean_buffer: RTL and testbench
====================================

Name: block_mean_buffer

Overview:
Upstream stage of variance_unit.
- Captures one block of TOTAL_SAMPLES pixels from the pixel stream into a local buffer and accumulates their sum.
- Computes the block mean, then replays the stored samples with mean_out held stable, using the start_data/sample-stream contract variance_unit consumes.
- Holds one block at a time; the input is back-pressured while a block is being replayed.

Parameters:
- DATA_WIDTH, 8: sample width in bits.
- TOTAL_SAMPLES, 64: samples per block; must be a power of 2.
- TOTAL_SAMPLES_WIDTH, 6: log2(TOTAL_SAMPLES); width of the address counter.
- DRAIN_CYCLES, 3: idle cycles after replay so the downstream pipeline can finish.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  DATA_WIDTH  input sample.
- data_valid_in  input  1  data_in valid this cycle.
- in_ready  output  1  block accepts a sample this cycle.
- data_out  output  DATA_WIDTH  replayed sample.
- data_valid_out  output  1  data_out valid.
- start_data_out  output  1  one-cycle pulse preceding each replay; drives variance_unit start_data_in.
- mean_out  output  DATA_WIDTH  block mean, stable from the START cycle through the end of DRAIN.
- block_done  output  1  one-cycle pulse on the last DRAIN cycle.

Behaviour:
- Reset: state=FILL, address=0, sum=0, in_ready=1, and data_out, data_valid_out, start_data_out, mean_out, block_done all 0. Reset mid-operation discards any partial block or replay immediately.
- Sample acceptance: a sample is accepted when data_valid_in && in_ready. It is written to buf[address], sum += data_in, address++. Input bubbles (valid low) are allowed; address and sum hold.
- Accumulator: sum is DATA_WIDTH+TOTAL_SAMPLES_WIDTH bits, so it never overflows (64×255=16320 fits in 14 bits).
- FILL: in_ready=1. On acceptance of sample TOTAL_SAMPLES-1, address wraps to 0 and the FSM goes to MEAN.
- MEAN (1 cycle): in_ready=0. mean_out <= sum >> TOTAL_SAMPLES_WIDTH, sum cleared. Go to START.
- START (1 cycle): start_data_out=1, data_valid_out=0. Go to REPLAY.
- REPLAY (TOTAL_SAMPLES cycles): on consecutive cycles, data_out=buf[address] and data_valid_out=1, in order 0..TOTAL_SAMPLES-1. No stalls, no downstream back-pressure.
- DRAIN (DRAIN_CYCLES cycles): data_valid_out=0, data_out=0. block_done pulses on the final cycle; then go to FILL with in_ready=1 on the next cycle.
- Latency: if the last sample is accepted at edge N, mean_out is valid after N+1, start_data_out is high in cycle N+2, and samples appear in cycles N+3..N+66.
- Outputs are registered; buffer read is synchronous (address issued one cycle ahead so data_out aligns with data_valid_out).
- data_valid_in while in_ready=0: ignored, and no state change.
- mean_out is not modified until the next MEAN state.

Optional Feature:
- BLOCK_MEAN_ROUND_EN defined: mean_out = (sum + TOTAL_SAMPLES/2) >> TOTAL_SAMPLES_WIDTH, i.e. round half up. The sum register is wide enough that this never overflows.
- Undefined: truncating shift.

Decomposition:
- Shared package (e.g. block_stats_pkg): state enum typedef {FILL, MEAN, START, REPLAY, DRAIN}, the DATA_WIDTH/TOTAL_SAMPLES defaults, and the sum-width constant. variance_unit and later noise-estimation stages reuse these.
- One sub-module: block_sample_ram, a single-port synchronous-read memory of TOTAL_SAMPLES×DATA_WIDTH (write in FILL, read in REPLAY). It is swappable for an SRAM macro.

Test Plan:
- 64 samples of 100, valid every cycle -> mean_out=100; start pulse 2 cycles after last accept; 64 outputs of 100; block_done after 3 drain cycles.
- Ramp 0..63 -> sum 2016; mean_out=31 (truncate) or 32 with BLOCK_MEAN_ROUND_EN; replay order 0..63 exact.
- All 255 -> mean_out=255 in both builds (16320>>6, 16352>>6), no overflow.
- Ramp with random valid bubbles, plus data_valid_in held high during REPLAY/DRAIN -> only the 64 FILL samples captured; replay identical to the no-bubble case; in_ready low from MEAN until DRAIN exit.
- rst asserted at REPLAY sample 20 -> all outputs 0 immediately; in_ready=1 after release; a new block of 7s yields mean_out=7 with no stale data.
- Back-to-back blocks (ramp, then constant 9) -> second mean_out=9; mean_out held at 31 until the second MEAN cycle.

Source files
------------

// File: rtl/block_mean_buffer_pkg.sv
// block_mean_buffer_pkg: shared types and defaults for the block statistics stages
// (block_mean_buffer, variance_unit and later noise-estimation stages).
// Holds the block FSM state encoding, default geometry and the accumulator width helper.
package block_mean_buffer_pkg;

  localparam int DATA_WIDTH_DEF          = 8;
  localparam int TOTAL_SAMPLES_DEF       = 64;
  localparam int TOTAL_SAMPLES_WIDTH_DEF = 6;
  localparam int DRAIN_CYCLES_DEF        = 3;

  // A sum of 2**tsw samples of dw bits needs dw+tsw bits and can never overflow.
  function automatic int sum_width(input int dw, input int tsw);
    return dw + tsw;
  endfunction

  localparam int SUM_WIDTH_DEF = sum_width(DATA_WIDTH_DEF, TOTAL_SAMPLES_WIDTH_DEF);

  typedef enum logic [2:0] {
    FILL   = 3'd0,
    MEAN   = 3'd1,
    START  = 3'd2,
    REPLAY = 3'd3,
    DRAIN  = 3'd4
  } blk_state_e;

endpackage

// File: rtl/block_sample_ram.sv
// block_sample_ram: single-port TOTAL_SAMPLES x DATA_WIDTH sample store, drop-in for an SRAM macro.
// Latency: write takes effect at the clock edge; read data appears one edge after the address.
// Backpressure: none; one access per cycle, write has priority (rdata holds during writes).
// Ports: clk; we = write enable; addr = shared read/write address; wdata = write data;
//        rdata = registered read data.
module block_sample_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // No reset: contents are always rewritten during FILL before they are replayed.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/block_mean_buffer.sv
// block_mean_buffer: captures a block of TOTAL_SAMPLES pixels, computes its mean, replays them.
// Latency: last sample accepted at edge N -> mean_out after N+1, start pulse next cycle, samples follow.
// Backpressure: in_ready is low from MEAN until DRAIN exits; downstream cannot stall the replay.
// Ports: clk, rst (async, active high); data_in/data_valid_in/in_ready = sample input;
//        data_out/data_valid_out = replayed samples; start_data_out = pulse before replay;
//        mean_out = block mean held until the next block's MEAN; block_done = last DRAIN cycle.
// Build option: define BLOCK_MEAN_ROUND_EN for round-half-up mean instead of truncation.
module block_mean_buffer
  import block_mean_buffer_pkg::*;
#(
  parameter int DATA_WIDTH          = DATA_WIDTH_DEF,
  parameter int TOTAL_SAMPLES       = TOTAL_SAMPLES_DEF,
  parameter int TOTAL_SAMPLES_WIDTH = TOTAL_SAMPLES_WIDTH_DEF,
  parameter int DRAIN_CYCLES        = DRAIN_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid_in,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid_out,
  output logic                  start_data_out,
  output logic [DATA_WIDTH-1:0] mean_out,
  output logic                  block_done
);

  localparam int SUM_W = sum_width(DATA_WIDTH, TOTAL_SAMPLES_WIDTH);

  typedef logic [TOTAL_SAMPLES_WIDTH-1:0] addr_t;

  localparam addr_t LAST_ADDR  = addr_t'(TOTAL_SAMPLES - 1);
  // The shared counter also times DRAIN, so DRAIN_CYCLES must not exceed TOTAL_SAMPLES.
  localparam addr_t LAST_DRAIN = addr_t'(DRAIN_CYCLES - 1);

  blk_state_e            state, state_nxt;
  addr_t                 addr, addr_nxt;
  addr_t                 cnt, cnt_nxt;
  logic [SUM_W-1:0]      sum, sum_nxt;
  logic [DATA_WIDTH-1:0] mean_nxt;
  logic [DATA_WIDTH-1:0] ram_rdat;
  logic                  accept_vld;

  assign accept_vld = data_valid_in && in_ready;

`ifdef BLOCK_MEAN_ROUND_EN
  assign mean_nxt = DATA_WIDTH'((sum + SUM_W'(TOTAL_SAMPLES / 2)) >> TOTAL_SAMPLES_WIDTH);
`else
  assign mean_nxt = DATA_WIDTH'(sum >> TOTAL_SAMPLES_WIDTH);
`endif

  // One address counter serves both ports of the single-port RAM: it is the write
  // pointer in FILL and runs as a read pointer from MEAN onward, two reads ahead of
  // data_out (RAM read register + output register), so buf[0] is read during MEAN.
  block_sample_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (TOTAL_SAMPLES),
    .ADDR_WIDTH(TOTAL_SAMPLES_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (accept_vld),
    .addr (addr),
    .wdata(data_in),
    .rdata(ram_rdat)
  );

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    cnt_nxt   = cnt;
    sum_nxt   = sum;
    case (state)
      FILL: begin
        if (accept_vld) begin
          addr_nxt = addr + 1'b1;  // wraps to 0 after the last sample
          sum_nxt  = sum + SUM_W'(data_in);
          if (addr == LAST_ADDR) begin
            state_nxt = MEAN;
          end
        end
      end
      MEAN: begin
        addr_nxt  = addr + 1'b1;
        sum_nxt   = '0;
        state_nxt = START;
      end
      START: begin
        addr_nxt  = addr + 1'b1;
        cnt_nxt   = '0;
        state_nxt = REPLAY;
      end
      REPLAY: begin
        // Reads past the block wrap harmlessly; their data is never shown.
        addr_nxt = addr + 1'b1;
        cnt_nxt  = cnt + 1'b1;
        if (cnt == LAST_ADDR) begin
          addr_nxt  = '0;
          cnt_nxt   = '0;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST_DRAIN) begin
          cnt_nxt   = '0;
          state_nxt = FILL;
        end
      end
      default: begin
        addr_nxt  = '0;
        cnt_nxt   = '0;
        sum_nxt   = '0;
        state_nxt = FILL;
      end
    endcase
  end

  // Outputs are decoded from the next state so every output is a plain flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= FILL;
      addr           <= '0;
      cnt            <= '0;
      sum            <= '0;
      in_ready       <= 1'b1;
      data_out       <= '0;
      data_valid_out <= 1'b0;
      start_data_out <= 1'b0;
      mean_out       <= '0;
      block_done     <= 1'b0;
    end else begin
      state          <= state_nxt;
      addr           <= addr_nxt;
      cnt            <= cnt_nxt;
      sum            <= sum_nxt;
      in_ready       <= (state_nxt == FILL);
      start_data_out <= (state_nxt == START);
      data_valid_out <= (state_nxt == REPLAY);
      data_out       <= (state_nxt == REPLAY) ? ram_rdat : '0;
      block_done     <= (state_nxt == DRAIN) && (cnt_nxt == LAST_DRAIN);
      if (state == MEAN) begin
        mean_out <= mean_nxt;
      end
    end
  end

endmodule

// File: tb/tb_block_mean_buffer.sv
// tb_block_mean_buffer: table of blocks (pattern, bubbles, expected mean) driven through
// block_mean_buffer; replayed samples are checked against a queue filled at drive time.
// Hand-written sequences cover reset in the middle of a replay and a fresh block afterwards.
module tb_block_mean_buffer;

  localparam int DW = 8;
  localparam int NS = 64;

`ifdef BLOCK_MEAN_ROUND_EN
  localparam logic [7:0] RAMP_MEAN = 8'd32;
`else
  localparam logic [7:0] RAMP_MEAN = 8'd31;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          data_valid_in = 1'b0;
  logic          in_ready;
  logic [DW-1:0] data_out;
  logic          data_valid_out;
  logic          start_data_out;
  logic [DW-1:0] mean_out;
  logic          block_done;

  int n_vec  = 0;
  int n_miss = 0;
  logic [7:0] sb[$];
  logic [7:0] prev_mean = 8'd0;

  always #5 clk = ~clk;

  block_mean_buffer #(
    .DATA_WIDTH(DW), .TOTAL_SAMPLES(NS), .TOTAL_SAMPLES_WIDTH(6), .DRAIN_CYCLES(3)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid_in(data_valid_in),
    .in_ready(in_ready), .data_out(data_out), .data_valid_out(data_valid_out),
    .start_data_out(start_data_out), .mean_out(mean_out), .block_done(block_done)
  );

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every valid replay beat must match the oldest captured sample.
  always @(negedge clk) begin
    if (!rst && data_valid_out) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL replay_extra: got data %0d with empty scoreboard (t=%0t)", data_out, $time);
      end else begin
        check("replay_data", int'(data_out), int'(sb.pop_front()));
      end
    end
  end

  // kind 0 = constant base, kind 1 = ramp starting at base.
  // abort_at >= 0 asserts rst during replay beat abort_at and returns early.
  task automatic run_block(input int kind, input int base, input int bubble, input bit hold,
                           input logic [7:0] mean_exp, input int abort_at);
    int i;
    int vcnt;
    int bad_rdy;
    int bad_start;
    int dv_drain;
    logic [2:0] done_pat;
    logic [7:0] s;
    i = 0;
    @(negedge clk);
    check("fill_in_ready", int'(in_ready), 1);
    while (i < NS) begin
      if (bubble > 0 && $urandom_range(0, 99) < bubble) begin
        data_valid_in = 1'b0;
        data_in = 8'($urandom);
      end else begin
        s = (kind == 0) ? 8'(base) : 8'(base + i);
        data_valid_in = 1'b1;
        data_in = s;
        sb.push_back(s);
        i++;
      end
      @(negedge clk);
    end
    // MEAN cycle: input closed, previous mean still held.
    data_valid_in = hold;
    data_in = 8'hAA;
    check("mean_in_ready", int'(in_ready), 0);
    check("mean_hold", int'(mean_out), int'(prev_mean));
    check("mean_no_start", int'(start_data_out), 0);
    // START cycle.
    @(negedge clk);
    check("start_pulse", int'(start_data_out), 1);
    check("start_mean", int'(mean_out), int'(mean_exp));
    check("start_no_valid", int'(data_valid_out), 0);
    vcnt = 0;
    bad_rdy = 0;
    bad_start = 0;
    for (int k = 0; k < NS; k++) begin
      @(negedge clk);
      data_in = 8'($urandom);
      if (k == abort_at) begin
        #2 rst = 1'b1;
        #1;
        check("rst_outputs", int'({in_ready, data_valid_out, start_data_out, block_done,
                                   data_out, mean_out}), int'({1'b1, 3'b000, 16'h0000}));
        data_valid_in = 1'b0;
        return;
      end
      if (data_valid_out) vcnt++;
      if (in_ready) bad_rdy++;
      if (start_data_out) bad_start++;
    end
    check("replay_beats", vcnt, NS);
    check("replay_start_low", bad_start, 0);
    done_pat = 3'b000;
    dv_drain = 0;
    for (int d = 0; d < 3; d++) begin
      @(negedge clk);
      done_pat = {done_pat[1:0], block_done};
      if (data_valid_out || data_out != 0) dv_drain++;
      if (in_ready) bad_rdy++;
    end
    check("in_ready_low_replay_drain", bad_rdy, 0);
    check("drain_quiet", dv_drain, 0);
    check("block_done_pattern", int'(done_pat), 1);
    @(negedge clk);
    data_valid_in = 1'b0;
    check("fill_reopen", int'(in_ready), 1);
    check("done_single", int'(block_done), 0);
    check("mean_after_drain", int'(mean_out), int'(mean_exp));
    check("sb_drained", sb.size(), 0);
    prev_mean = mean_exp;
  endtask

  typedef struct {
    int         kind;
    int         base;
    int         bubble;
    bit         hold;
    logic [7:0] mean_exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{kind: 0, base: 100, bubble: 0,  hold: 1'b0, mean_exp: 8'd100};
    vecs[1] = '{kind: 1, base: 0,   bubble: 0,  hold: 1'b0, mean_exp: RAMP_MEAN};
    vecs[2] = '{kind: 0, base: 255, bubble: 0,  hold: 1'b0, mean_exp: 8'd255};
    vecs[3] = '{kind: 1, base: 0,   bubble: 30, hold: 1'b1, mean_exp: RAMP_MEAN};
    vecs[4] = '{kind: 1, base: 0,   bubble: 0,  hold: 1'b0, mean_exp: RAMP_MEAN};
    vecs[5] = '{kind: 0, base: 9,   bubble: 0,  hold: 1'b1, mean_exp: 8'd9};

    #12;
    check("reset_outputs", int'({in_ready, data_valid_out, start_data_out, block_done,
                                 data_out, mean_out}), int'({1'b1, 3'b000, 16'h0000}));
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      run_block(vecs[v].kind, vecs[v].base, vecs[v].bubble, vecs[v].hold,
                vecs[v].mean_exp, -1);
    end

    // Reset during replay beat 20, then a fresh block of 7s.
    run_block(1, 0, 0, 1'b0, RAMP_MEAN, 20);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    prev_mean = 8'd0;
    @(negedge clk);
    check("post_rst_in_ready", int'(in_ready), 1);
    check("post_rst_quiet", int'({data_valid_out, start_data_out, block_done}), 0);
    run_block(0, 7, 0, 1'b0, 8'd7, -1);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
